// File: rtl/secuenciador_multiciclo_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, opcodes,
// ALU select codes, instruction field positions and the decoded-control bundle.
// Latency: n/a (definitions only). Backpressure: n/a.
package secuenciador_multiciclo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  // Opcodes
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU operation selects
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Instruction fields: op[19:16], spare[15], rs1[14:10], rs2[9:5], rd[4:0]
  localparam int OP_HI  = 19;
  localparam int OP_LO  = 16;
  localparam int SPARE  = 15;
  localparam int RS1_HI = 14;
  localparam int RS1_LO = 10;
  localparam int RS2_HI = 9;
  localparam int RS2_LO = 5;
  localparam int RD_HI  = 4;
  localparam int RD_LO  = 0;

  typedef struct packed {
    logic       we_rb;
    logic       write_ram;
    logic       demux;
    logic [3:0] alu_opcode;
    logic       illegal;
    logic       halt;
  } ctrl_t;

endpackage

// File: rtl/secuenciador_multiciclo_if.sv
// Sequencer <-> instruction ROM / datapath bus. master = sequencer side.
// Latency: instr_data is valid one cycle after instr_addr. Backpressure: none.
// Ports: instr_addr/instr_data (ROM), ra1/ra2/wa (RB addresses), strobes, alu_opcode, demultiplexor.
interface secuenciador_multiciclo_if #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 20
);
  logic [PC_W-1:0]    instr_addr;
  logic [INSTR_W-1:0] instr_data;
  logic [4:0]         ra1;
  logic [4:0]         ra2;
  logic [4:0]         wa;
  logic               write_enable_RB;
  logic               read_ram;
  logic               write_ram;
  logic [3:0]         alu_opcode;
  logic               demultiplexor;

  modport master (
    output instr_addr, ra1, ra2, wa, write_enable_RB, read_ram, write_ram,
           alu_opcode, demultiplexor,
    input  instr_data
  );

  modport slave (
    input  instr_addr, ra1, ra2, wa, write_enable_RB, read_ram, write_ram,
           alu_opcode, demultiplexor,
    output instr_data
  );
endinterface

// File: rtl/secuenciador_multiciclo_decodificador_instr.sv
// Opcode decoder: op[3:0] -> {we_rb, write_ram, demux, alu_opcode, illegal, halt}.
// Latency: combinational. Backpressure: none; outputs are ungated, the caller qualifies by state.
// Ports: op (in), ctrl (out, ctrl_t).
module decodificador_instr
  import secuenciador_multiciclo_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_AND:  begin ctrl.we_rb = 1'b1; ctrl.alu_opcode = ALU_AND; end
      OP_OR:   begin ctrl.we_rb = 1'b1; ctrl.alu_opcode = ALU_OR;  end
      OP_ADD:  begin ctrl.we_rb = 1'b1; ctrl.alu_opcode = ALU_ADD; end
      OP_SUB:  begin ctrl.we_rb = 1'b1; ctrl.alu_opcode = ALU_SUB; end
      OP_SLT:  begin ctrl.we_rb = 1'b1; ctrl.alu_opcode = ALU_SLT; end
      OP_NOR:  begin ctrl.we_rb = 1'b1; ctrl.alu_opcode = ALU_NOR; end
      OP_SW:   begin ctrl.write_ram = 1'b1; ctrl.demux = 1'b1; ctrl.alu_opcode = ALU_AND; end
      OP_HALT: ctrl.halt = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/secuenciador_multiciclo.sv
// Multi-cycle sequencer: FETCH-DECODE-EXECUTE-WRITE per instruction, owns PC/IR/retired count/err.
// Latency: 4 cycles per non-HALT instruction; start edge to first WRITE is 4 cycles.
// Backpressure: none; ROM read is fixed 1-cycle latency, start is ignored while busy.
// Ports: clk, rst (sync, active-high), start, bus (master), busy, done, err, instr_count.
module secuenciador_multiciclo
  import secuenciador_multiciclo_pkg::*;
#(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 20,
  parameter int CNT_W   = 16
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  secuenciador_multiciclo_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [CNT_W-1:0]          instr_count
);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [4:0]         ra1_q, ra2_q, wa_q;
  logic [3:0]         alu_q;
  logic               demux_q, we_rb_q, wr_ram_q;
  logic [3:0]         dec_op;
  ctrl_t              ctrl;
  logic               unused_spare;

  // In DECODE the IR is still being loaded, so decode straight from the ROM
  // data; in every later state the IR is the source.
  assign dec_op = (state == ST_DECODE) ? bus.instr_data[OP_HI:OP_LO] : ir[OP_HI:OP_LO];

  decodificador_instr u_dec (
    .op   (dec_op),
    .ctrl (ctrl)
  );

  assign bus.instr_addr    = pc;
  assign bus.ra1           = ra1_q;
  assign bus.ra2           = ra2_q;
  assign bus.wa            = wa_q;
  assign bus.alu_opcode    = alu_q;
  assign bus.demultiplexor = demux_q;
  // A reset arriving during WRITE must stop the write landing on that edge.
  assign bus.write_enable_RB = we_rb_q & ~rst;
  assign bus.write_ram       = wr_ram_q & ~rst;
  assign bus.read_ram        = 1'b0;
  assign unused_spare        = ir[SPARE];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      ir          <= '0;
      instr_count <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ra1_q       <= '0;
      ra2_q       <= '0;
      wa_q        <= '0;
      alu_q       <= '0;
      demux_q     <= 1'b0;
      we_rb_q     <= 1'b0;
      wr_ram_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
            err         <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          ir <= bus.instr_data;
          if (ctrl.halt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_HALT;
          end else begin
            // Addresses, ALU select and demux become visible in EXECUTE.
            ra1_q   <= bus.instr_data[RS1_HI:RS1_LO];
            ra2_q   <= bus.instr_data[RS2_HI:RS2_LO];
            wa_q    <= bus.instr_data[RD_HI:RD_LO];
            alu_q   <= ctrl.alu_opcode;
            demux_q <= ctrl.demux;
            state   <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          we_rb_q  <= ctrl.we_rb;
          wr_ram_q <= ctrl.write_ram;
          err      <= err | ctrl.illegal;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          we_rb_q  <= 1'b0;
          wr_ram_q <= 1'b0;
          ra1_q    <= '0;
          ra2_q    <= '0;
          wa_q     <= '0;
          alu_q    <= '0;
          demux_q  <= 1'b0;
          pc       <= pc + PC_W'(1);
          if (instr_count != {CNT_W{1'b1}})
            instr_count <= instr_count + CNT_W'(1);
          state    <= ST_FETCH;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          we_rb_q  <= 1'b0;
          wr_ram_q <= 1'b0;
          demux_q  <= 1'b0;
          alu_q    <= '0;
        end
      endcase
    end
  end

endmodule
